// File: rtl/hazard_pkg.sv
// Shared encodings for the pipeline hazard controller.
//   FWD_*      : EX-stage forwarding mux selects (SrcA / SrcB)
//   RES_*      : result-source encodings carried with each instruction
//   hz_state_t : data-memory wait FSM states
package hazard_pkg;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;
  localparam logic [1:0] FWD_IMM = 2'b11;

  localparam logic [1:0] RES_ALU  = 2'b00;
  localparam logic [1:0] RES_LOAD = 2'b01;
  localparam logic [1:0] RES_PC4  = 2'b10;
  localparam logic [1:0] RES_IMM  = 2'b11;

  typedef enum logic [1:0] {
    RUN      = 2'b00,
    MEM_WAIT = 2'b01,
    MEM_ERR  = 2'b10
  } hz_state_t;

endpackage

// File: rtl/mem_wait_fsm.sv
// Data-memory wait tracker for the MEM stage.
//   state    | meaning
//   RUN      | no outstanding access; a request without ack starts a wait
//   MEM_WAIT | access outstanding; waitCnt counts stalled cycles so far
//   MEM_ERR  | access timed out; pipeline frozen until rst
// Ports:
//   clk, rst          clock, async active-high reset
//   memReqM, memAckM  MEM-stage request / completion
//   memWait           pipeline must hold this cycle (combinational)
//   memErr            sticky timeout flag
module mem_wait_fsm
  import hazard_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic memReqM,
  input  logic memAckM,
  output logic memWait,
  output logic memErr
);

  localparam int CNT_W = $clog2(MEM_TIMEOUT);

  hz_state_t        state, state_nxt;
  logic [CNT_W-1:0] waitCnt, cnt_nxt;
  logic             err_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= RUN;
      waitCnt <= '0;
      memErr  <= 1'b0;
    end else begin
      state   <= state_nxt;
      waitCnt <= cnt_nxt;
      memErr  <= err_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = waitCnt;
    err_nxt   = memErr;
    memWait   = 1'b0;
    case (state)
      RUN: begin
        if (memReqM && !memAckM) begin
          memWait   = 1'b1;
          state_nxt = MEM_WAIT;
          cnt_nxt   = CNT_W'(1);
        end
      end
      MEM_WAIT: begin
        if (memAckM) begin
          // ack releases the pipeline in the same cycle it arrives
          state_nxt = RUN;
          cnt_nxt   = '0;
        end else begin
          memWait = 1'b1;
          if (waitCnt == CNT_W'(MEM_TIMEOUT - 1)) begin
            state_nxt = MEM_ERR;
            err_nxt   = 1'b1;
          end else begin
            cnt_nxt = waitCnt + CNT_W'(1);
          end
        end
      end
      MEM_ERR: begin
        memWait = 1'b1;
      end
      default: begin
        state_nxt = RUN;
        cnt_nxt   = '0;
      end
    endcase
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard and stall controller for the 5-stage RISC-V pipeline.
// Build option: HAZARD_PERF_EN adds saturating stall/flush performance counters;
// without it perfStall/perfFlush read 0.
// Ports:
//   clk, rst                     clock, async active-high reset
//   Rs1D/Rs2D, Rs1E/Rs2E         source registers in ID / EX
//   RdE, resultSrcE              EX destination and result select (load detection)
//   RdM, regWriteM, resultSrcM   MEM writeback info (forward source)
//   RdW, regWriteW               WB writeback info (forward source)
//   PCSrcE                       taken branch/jump resolved in EX
//   memReqM, memAckM             data-memory handshake
//   forwardAE, forwardBE         EX SrcA/SrcB forwarding selects
//   stallF/D/E/M, flushD/E/W     pipeline register controls
//   memErr                       sticky memory-timeout flag
//   perfStall, perfFlush         performance counters
module pipeline_hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int PERF_W      = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [4:0]        Rs1D,
  input  logic [4:0]        Rs2D,
  input  logic [4:0]        Rs1E,
  input  logic [4:0]        Rs2E,
  input  logic [4:0]        RdE,
  input  logic [1:0]        resultSrcE,
  input  logic [4:0]        RdM,
  input  logic [4:0]        RdW,
  input  logic              regWriteM,
  input  logic              regWriteW,
  input  logic [1:0]        resultSrcM,
  input  logic              PCSrcE,
  input  logic              memReqM,
  input  logic              memAckM,
  output logic [1:0]        forwardAE,
  output logic [1:0]        forwardBE,
  output logic              stallF,
  output logic              stallD,
  output logic              stallE,
  output logic              stallM,
  output logic              flushD,
  output logic              flushE,
  output logic              flushW,
  output logic              memErr,
  output logic [PERF_W-1:0] perfStall,
  output logic [PERF_W-1:0] perfFlush
);

  logic memWait;
  logic lwStall;

  mem_wait_fsm #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_mem_wait (
    .clk     (clk),
    .rst     (rst),
    .memReqM (memReqM),
    .memAckM (memAckM),
    .memWait (memWait),
    .memErr  (memErr)
  );

  // MEM has priority over WB (younger result); x0 is never forwarded.
  function automatic logic [1:0] fwd_sel(input logic [4:0] rs);
    logic [1:0] sel;
    sel = FWD_RF;
    if (rs != 5'd0) begin
      if (regWriteM && RdM == rs)
        sel = (resultSrcM == RES_IMM) ? FWD_IMM : FWD_MEM;
      else if (regWriteW && RdW == rs)
        sel = FWD_WB;
    end
    return sel;
  endfunction

  always_comb begin
    forwardAE = fwd_sel(Rs1E);
    forwardBE = fwd_sel(Rs2E);
  end

  // A taken branch makes the ID instruction wrong-path, so no load-use stall.
  assign lwStall = (resultSrcE == RES_LOAD) && (RdE != 5'd0) &&
                   ((RdE == Rs1D) || (RdE == Rs2D)) && !PCSrcE;

  // A memory wait freezes everything; branch/load-use act once it releases.
  always_comb begin
    stallF = memWait | lwStall;
    stallD = memWait | lwStall;
    stallE = memWait;
    stallM = memWait;
    flushW = memWait;
    flushD = !memWait & PCSrcE;
    flushE = !memWait & (PCSrcE | lwStall);
  end

`ifdef HAZARD_PERF_EN
  logic [PERF_W-1:0] stall_cnt, flush_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stallF && stall_cnt != '1)
        stall_cnt <= stall_cnt + PERF_W'(1);
      if (PCSrcE && !memWait && flush_cnt != '1)
        flush_cnt <= flush_cnt + PERF_W'(1);
    end
  end

  assign perfStall = stall_cnt;
  assign perfFlush = flush_cnt;
`else
  assign perfStall = '0;
  assign perfFlush = '0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl (MEM_TIMEOUT=4): directed
// scenarios then randomized traffic against a behavioural reference model.
module tb_pipeline_hazard_ctrl;

  localparam int TMO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic [1:0]  resultSrcE, resultSrcM;
  logic        regWriteM, regWriteW, PCSrcE, memReqM, memAckM;
  logic [1:0]  forwardAE, forwardBE;
  logic        stallF, stallD, stallE, stallM, flushD, flushE, flushW, memErr;
  logic [31:0] perfStall, perfFlush;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.MEM_TIMEOUT(TMO), .PERF_W(32)) dut (
    .clk(clk), .rst(rst),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE),
    .resultSrcE(resultSrcE), .RdM(RdM), .RdW(RdW),
    .regWriteM(regWriteM), .regWriteW(regWriteW), .resultSrcM(resultSrcM),
    .PCSrcE(PCSrcE), .memReqM(memReqM), .memAckM(memAckM),
    .forwardAE(forwardAE), .forwardBE(forwardBE),
    .stallF(stallF), .stallD(stallD), .stallE(stallE), .stallM(stallM),
    .flushD(flushD), .flushE(flushE), .flushW(flushW), .memErr(memErr),
    .perfStall(perfStall), .perfFlush(perfFlush)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model state: memory access outstanding, number of consecutive
  // stalled memory cycles, timeout latched, performance tallies.
  bit in_wait, err;
  int wait_cycles;
  int ref_stalls, ref_flushes;

  logic [1:0] e_fa, e_fb;
  bit e_mw, e_lw, e_stF, e_flD, e_flE;

  function automatic logic [1:0] ref_fwd(input logic [4:0] rs);
    if (rs == 0) return 2'b00;
    if (regWriteM && RdM == rs) return (resultSrcM == 2'b11) ? 2'b11 : 2'b10;
    if (regWriteW && RdW == rs) return 2'b01;
    return 2'b00;
  endfunction

  task automatic model_eval();
    e_fa  = ref_fwd(Rs1E);
    e_fb  = ref_fwd(Rs2E);
    e_mw  = err || ((in_wait || memReqM) && !memAckM);
    e_lw  = resultSrcE == 2'b01 && RdE != 0 && (RdE == Rs1D || RdE == Rs2D) && !PCSrcE;
    e_stF = e_mw || e_lw;
    e_flD = !e_mw && PCSrcE;
    e_flE = !e_mw && (PCSrcE || e_lw);
  endtask

  task automatic model_reset();
    in_wait = 0; err = 0; wait_cycles = 0; ref_stalls = 0; ref_flushes = 0;
  endtask

  task automatic model_clock();
    if (e_stF) ref_stalls++;
    if (PCSrcE && !e_mw) ref_flushes++;
    if (!err) begin
      if (e_mw) begin
        in_wait = 1;
        wait_cycles++;
        if (wait_cycles == TMO) err = 1;
      end else begin
        in_wait = 0;
        wait_cycles = 0;
      end
    end
  endtask

  task automatic check_all();
    #1;
    model_eval();
    chk("forwardAE", forwardAE, e_fa);
    chk("forwardBE", forwardBE, e_fb);
    chk("stallF", stallF, e_stF);
    chk("stallD", stallD, e_stF);
    chk("stallE", stallE, e_mw);
    chk("stallM", stallM, e_mw);
    chk("flushD", flushD, e_flD);
    chk("flushE", flushE, e_flE);
    chk("flushW", flushW, e_mw);
    chk("memErr", memErr, err);
`ifdef HAZARD_PERF_EN
    chk("perfStall", perfStall, ref_stalls);
    chk("perfFlush", perfFlush, ref_flushes);
`else
    chk("perfStall", perfStall, 0);
    chk("perfFlush", perfFlush, 0);
`endif
  endtask

  // Check current inputs, clock once, return just after the next negedge.
  task automatic step();
    check_all();
    @(posedge clk);
    model_clock();
    @(negedge clk);
  endtask

  task automatic zero_inputs();
    Rs1D = 0; Rs2D = 0; Rs1E = 0; Rs2E = 0; RdE = 0; RdM = 0; RdW = 0;
    resultSrcE = 0; resultSrcM = 0; regWriteM = 0; regWriteW = 0;
    PCSrcE = 0; memReqM = 0; memAckM = 0;
  endtask

  task automatic do_reset();
    zero_inputs();
    rst = 1'b1;
    #1;
    model_reset();
    chk("rst_stallF", stallF, 0);
    chk("rst_stallM", stallM, 0);
    chk("rst_flushW", flushW, 0);
    chk("rst_memErr", memErr, 0);
    chk("rst_fwdA", forwardAE, 0);
    chk("rst_perfS", perfStall, 0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    zero_inputs();
    @(negedge clk);
    do_reset();
    step();

    // forwarding: MEM beats WB, LUI in MEM selects extImm
    RdM = 5; regWriteM = 1; Rs1E = 5; RdW = 5; regWriteW = 1;
    #1 chk("fwd_mem", forwardAE, 2'b10);
    step();
    resultSrcM = 2'b11;
    #1 chk("fwd_imm", forwardAE, 2'b11);
    step();
    zero_inputs(); regWriteM = 1;
    #1 chk("fwd_x0", forwardAE, 2'b00);
    step();
    zero_inputs(); RdM = 3; RdW = 3; regWriteW = 1; Rs2E = 3;
    #1 chk("fwd_wb", forwardBE, 2'b01);
    step();

    // load-use, then branch suppressing it
    zero_inputs(); resultSrcE = 2'b01; RdE = 7; Rs2D = 7;
    #1 chk("lw_stallF", stallF, 1);
    chk("lw_flushE", flushE, 1);
    chk("lw_stallE", stallE, 0);
    step();
    PCSrcE = 1;
    #1 chk("br_stallF", stallF, 0);
    chk("br_flushD", flushD, 1);
    step();

    // 3-cycle memory wait then one branch
    do_reset();
    memReqM = 1;
    for (int i = 0; i < 3; i++) begin
      #1 chk("wait_stallM", stallM, 1);
      step();
    end
    memAckM = 1;
    #1 chk("ack_stallF", stallF, 0);
    chk("ack_flushW", flushW, 0);
    step();
    zero_inputs(); PCSrcE = 1;
    step();
    zero_inputs();
    #1;
`ifdef HAZARD_PERF_EN
    chk("perf_stall3", perfStall, 3);
    chk("perf_flush1", perfFlush, 1);
`else
    chk("perf_off_s", perfStall, 0);
    chk("perf_off_f", perfFlush, 0);
`endif
    step();

    // timeout: ack never arrives
    memReqM = 1;
    for (int i = 0; i < TMO + 2; i++) step();
    memReqM = 0; memAckM = 1;
    #1 chk("err_sticky", memErr, 1);
    chk("err_frozen", stallF, 1);
    step();
    do_reset();
    step();

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 79) == 0) do_reset();
      Rs1D = 5'($urandom_range(0, 3)); Rs2D = 5'($urandom_range(0, 3));
      Rs1E = 5'($urandom_range(0, 3)); Rs2E = 5'($urandom_range(0, 3));
      RdE  = 5'($urandom_range(0, 3)); RdM  = 5'($urandom_range(0, 3));
      RdW  = 5'($urandom_range(0, 3));
      resultSrcE = 2'($urandom); resultSrcM = 2'($urandom);
      regWriteM = 1'($urandom); regWriteW = 1'($urandom);
      PCSrcE  = ($urandom_range(0, 4) == 0);
      memReqM = ($urandom_range(0, 2) == 0);
      memAckM = 1'($urandom);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
